// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding word request at a time,
// and presents fetched instructions to decode with redirect, kill and misalignment handling.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] iaddr_in,
    input  logic        branch_taken_in,
    input  logic        stall_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_valid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    output logic        misaligned_out
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            kill_q, kill_d;
    logic            req_d;
    logic [XLEN-1:0] addr_d;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] pc_d;
    logic            valid_d;
    logic            misaligned_d;
    logic            bad_target_c;

    assign bad_target_c = branch_taken_in && (iaddr_in[1:0] != 2'b00);

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        redir_pc_d   = redir_pc_q;
        kill_d       = kill_q;
        instr_d      = instr_out;
        pc_d         = pc_out;
        valid_d      = instr_valid_out;
        misaligned_d = misaligned_out;

        if (bad_target_c && (state_q != ERR)) begin
            state_d      = ERR;
            valid_d      = 1'b0;
            misaligned_d = 1'b1;
            kill_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_valid_in) begin
                        if (kill_q || branch_taken_in) begin
                            // Stale or overtaken response: drop it and re-request at the target.
                            fetch_pc_d = branch_taken_in ? iaddr_in : redir_pc_q;
                            kill_d     = 1'b0;
                        end else begin
                            instr_d    = imem_rdata_in;
                            pc_d       = fetch_pc_q;
                            valid_d    = 1'b1;
                            fetch_pc_d = fetch_pc_q + XLEN'(4);
                            state_d    = OUT;
                        end
                    end else if (branch_taken_in) begin
                        kill_d     = 1'b1;
                        redir_pc_d = iaddr_in;
                    end
                end
                OUT: begin
                    if (branch_taken_in) begin
                        valid_d    = 1'b0;
                        fetch_pc_d = iaddr_in;
                        state_d    = REQ;
                    end else if (!stall_in) begin
                        valid_d = 1'b0;
                        state_d = REQ;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        req_d  = (state_d == REQ);
        addr_d = fetch_pc_d;
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= IDLE;
            fetch_pc_q      <= RESET_PC;
            redir_pc_q      <= RESET_PC;
            kill_q          <= 1'b0;
            imem_req_out    <= 1'b0;
            imem_addr_out   <= RESET_PC;
            instr_out       <= NOP_INSTR;
            pc_out          <= RESET_PC;
            instr_valid_out <= 1'b0;
            misaligned_out  <= 1'b0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            redir_pc_q      <= redir_pc_d;
            kill_q          <= kill_d;
            imem_req_out    <= req_d;
            imem_addr_out   <= addr_d;
            instr_out       <= instr_d;
            pc_out          <= pc_d;
            instr_valid_out <= valid_d;
            misaligned_out  <= misaligned_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit for the RV32I core. It owns the program counter, issues word requests to instruction memory over a request/valid handshake, and presents each fetched instruction with its PC to decode. It consumes the jump/branch target address (`iaddr_in`) and the taken flag produced by the execute stage's target adder. It redirects fetch on a taken branch, including discarding a response that is already in flight.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_in  input  1  core clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- iaddr_in  input  32  redirect target from the execute-stage target adder.
- branch_taken_in  input  1  redirect request; `iaddr_in` is valid while this is high.
- stall_in  input  1  decode not ready; holds the presented instruction.
- imem_req_out  output  1  instruction memory request.
- imem_addr_out  output  32  request address.
- imem_valid_in  input  1  response valid; one cycle per request.
- imem_rdata_in  input  32  response word.
- instr_out  output  32  fetched instruction.
- pc_out  output  32  PC of `instr_out`.
- instr_valid_out  output  1  `instr_out` and `pc_out` are valid.
- misaligned_out  output  1  sticky flag: a redirect target was not word-aligned.

## Operation

- Internal state: `fetch_pc` (32), `kill` (1), `redir_pc` (32), FSM state in {IDLE, REQ, OUT, ERR}.
- Reset values: `imem_req_out`=0, `imem_addr_out`=RESET_PC, `instr_out`=32'h0000_0013 (NOP), `pc_out`=RESET_PC, `instr_valid_out`=0, `misaligned_out`=0, `fetch_pc`=RESET_PC, `kill`=0, state=IDLE.
- IDLE: go to REQ at the next edge, unconditionally.
- REQ:
  - `imem_req_out`=1 and `imem_addr_out`=`fetch_pc`.
  - Both stay stable until `imem_valid_in`; requests cannot be withdrawn, and only one is outstanding at a time.
  - On `imem_valid_in` with `kill`=0: register `instr_out`<=`imem_rdata_in`, `pc_out`<=`fetch_pc`, `instr_valid_out`<=1, `fetch_pc`<=`fetch_pc`+4. Go to OUT.
  - On `imem_valid_in` with `kill`=1, or with `branch_taken_in` high in the same cycle: discard the data. Set `fetch_pc`<=target and clear `kill`. Stay in REQ, so the next request goes to the target. The target is `iaddr_in` if `branch_taken_in` is high that cycle, else `redir_pc`.
  - `branch_taken_in` without `imem_valid_in`: `kill`<=1, `redir_pc`<=`iaddr_in`. If several redirects arrive before the response, the last one wins.
  - `stall_in` is ignored in REQ.
- OUT: `imem_req_out`=0.
  - `branch_taken_in` has priority: `instr_valid_out`<=0, `fetch_pc`<=`iaddr_in`, go to REQ.
  - Else if `stall_in`=0: the instruction is consumed this edge. `instr_valid_out`<=0, go to REQ.
  - Else hold: all outputs stay unchanged.
- Misalignment check: a redirect with `iaddr_in[1:0]`≠0 in any state goes to ERR instead.
  - ERR drives `misaligned_out`=1, `imem_req_out`=0 and `instr_valid_out`=0, and holds until reset.
  - If a request is outstanding on entry to ERR, its response is ignored.
- Arithmetic: PC increment is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Reset asserted mid-operation: every register returns to its reset value immediately, without waiting for a clock edge. Any response arriving after reset is released is ignored unless the FSM is in REQ.

## Timing

- From reset release, IDLE lasts 1 cycle; `imem_req_out` rises at the 1st edge after release.
- Fetch latency: `instr_valid_out` rises at the edge where `imem_valid_in` is sampled high, i.e. the cycle after the response.
- With 1-cycle memory and no stall, throughput is one instruction per 3 cycles (REQ, response, OUT).
- A redirect in OUT produces a request to the target at the next cycle.
- A redirect during an outstanding request costs the remaining wait plus 1 cycle. The discarded instruction never appears on `instr_valid_out`.
- `misaligned_out` rises the cycle after the bad redirect.

## Test plan

- Sequential fetch:
  - Stimulus: reset with RESET_PC=0; 1-cycle memory returns 0xA0, 0xA1, 0xA2.
  - Required: requests to 0x0, 0x4, 0x8; outputs (pc_out, instr_out) = (0x0, 0xA0), (0x4, 0xA1), (0x8, 0xA2), each valid for 1 cycle.
- Stall hold:
  - Stimulus: `stall_in`=1 for 4 cycles while OUT holds pc 0x4.
  - Required: `instr_out`, `pc_out` and `instr_valid_out` unchanged for those 4 cycles; no request issued; request to 0x8 on the cycle after stall drops.
- Redirect in flight:
  - Stimulus: request to 0x8 with 3-cycle memory latency; `branch_taken_in`=1 with `iaddr_in`=0x100 in the first wait cycle.
  - Required: response for 0x8 discarded; next request to 0x100; first valid output has pc_out=0x100.
- Redirect coincident with response:
  - Stimulus: `branch_taken_in`=1, `iaddr_in`=0x40 in the same cycle as `imem_valid_in`.
  - Required: no valid output for that response; next request to 0x40.
- Misaligned target:
  - Stimulus: redirect with `iaddr_in`=0x102 from OUT.
  - Required: `misaligned_out`=1 the next cycle and held; `imem_req_out` stays 0.
  - Then `rst_n_in` low mid-cycle: all outputs return to their reset values immediately; the fetch restarts at RESET_PC.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Required: the following request address is 0x0000_0000.
